// File: rtl/mem_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_read_arbiter
// Brief    : Round-robin, burst-bounded arbiter for the shared packet-memory
//            read port; tags each read and routes the returning block back.
// Revision : 1.0 - initial release
// ============================================================================
module mem_read_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int BLOCK_BYTES = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_PORTS   = 4,
    parameter int MEM_LAT     = 1,
    parameter int MAX_BURST   = 4
) (
    input  logic                                                 switch_clk,
    input  logic                                                 switch_rst_n,
    input  logic [NUM_PORTS-1:0]                                 req_re_i,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]                     req_addr_i,
    output logic [NUM_PORTS-1:0]                                 req_gnt_o,
    output logic [NUM_PORTS-1:0]                                 rvalid_o,
    output logic [NUM_PORTS-1:0][BLOCK_BYTES-1:0][DATA_WIDTH-1:0] rdata_o,
    output logic                                                 mem_re_o,
    output logic [ADDR_W-1:0]                                    mem_raddr_o,
    input  logic [BLOCK_BYTES-1:0][DATA_WIDTH-1:0]               mem_rdata_i
);

    localparam int               PTR_W      = $clog2(NUM_PORTS);
    localparam int               CNT_W      = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_BURST);
    localparam logic [PTR_W:0]   NPORTS_EXT = (PTR_W + 1)'(NUM_PORTS);
    localparam logic [PTR_W-1:0] LAST_PORT  = PTR_W'(NUM_PORTS - 1);

    logic [PTR_W-1:0]              rr_ptr;
    logic [PTR_W-1:0]              owner;
    logic                          owner_vld;
    logic [CNT_W-1:0]              burst_cnt;
    logic [MEM_LAT-1:0]            tag_vld;
    logic [MEM_LAT-1:0][PTR_W-1:0] tag_port;

    logic                          owner_keeps;
    logic                          gnt_vld;
    logic [PTR_W-1:0]              gnt_port;
    logic [PTR_W:0]                cand_sum;
    logic [PTR_W-1:0]              next_ptr;
    logic                          same_burst;

    // Grant selection. The round-robin scan runs from the farthest offset
    // down to rr_ptr so the nearest requester is the last (winning) write.
    always_comb begin
        owner_keeps = owner_vld && req_re_i[owner] && (burst_cnt < MAX_CNT);
        gnt_vld     = 1'b0;
        gnt_port    = '0;
        cand_sum    = '0;
        if (owner_keeps) begin
            gnt_vld  = 1'b1;
            gnt_port = owner;
        end else begin
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                cand_sum = {1'b0, rr_ptr} + (PTR_W + 1)'(i);
                if (cand_sum >= NPORTS_EXT) begin
                    cand_sum = cand_sum - NPORTS_EXT;
                end
                if (req_re_i[cand_sum[PTR_W-1:0]]) begin
                    gnt_vld  = 1'b1;
                    gnt_port = cand_sum[PTR_W-1:0];
                end
            end
        end
        // No read may be accepted while the block is held in reset.
        if (!switch_rst_n) begin
            gnt_vld = 1'b0;
        end
    end

    always_comb begin
        next_ptr   = (gnt_port == LAST_PORT) ? '0 : gnt_port + 1'b1;
        same_burst = owner_vld && (owner == gnt_port) && (burst_cnt < MAX_CNT);
    end

    always_ff @(posedge switch_clk or negedge switch_rst_n) begin
        if (!switch_rst_n) begin
            rr_ptr    <= '0;
            owner     <= '0;
            owner_vld <= 1'b0;
            burst_cnt <= '0;
        end else if (gnt_vld) begin
            rr_ptr    <= next_ptr;
            owner     <= gnt_port;
            owner_vld <= 1'b1;
            burst_cnt <= same_burst ? burst_cnt + 1'b1 : CNT_W'(1);
        end else begin
            owner_vld <= 1'b0;
            burst_cnt <= '0;
        end
    end

    // Requester tag travels alongside the memory access for MEM_LAT cycles.
    always_ff @(posedge switch_clk or negedge switch_rst_n) begin
        if (!switch_rst_n) begin
            tag_vld  <= '0;
            tag_port <= '0;
        end else begin
            tag_vld[0]  <= gnt_vld;
            tag_port[0] <= gnt_port;
            for (int s = 1; s < MEM_LAT; s++) begin
                tag_vld[s]  <= tag_vld[s-1];
                tag_port[s] <= tag_port[s-1];
            end
        end
    end

    assign mem_re_o    = gnt_vld;
    assign mem_raddr_o = gnt_vld ? req_addr_i[gnt_port] : '0;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign req_gnt_o[p] = gnt_vld && (gnt_port == PTR_W'(p));
        assign rvalid_o[p]  = tag_vld[MEM_LAT-1] && (tag_port[MEM_LAT-1] == PTR_W'(p));
        assign rdata_o[p]   = mem_rdata_i;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_read_arbiter
// Brief    : Directed self-checking bench for mem_read_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_read_arbiter;

    logic                  clk;
    logic                  rst_n;
    logic [3:0]            req_re;
    logic [3:0][15:0]      req_addr;
    logic [3:0][7:0]       mem_rdata;

    logic [3:0]            gnt_a, rvalid_a, gnt_b, rvalid_b, gnt_c, rvalid_c;
    logic [3:0][3:0][7:0]  rdata_a, rdata_b, rdata_c;
    logic                  mre_a, mre_b, mre_c;
    logic [15:0]           raddr_a, raddr_b, raddr_c;

    int errors = 0;
    int checks = 0;

    // Main configuration: MEM_LAT=1, MAX_BURST=4
    mem_read_arbiter #(.ADDR_W(16), .BLOCK_BYTES(4), .DATA_WIDTH(8), .NUM_PORTS(4),
                       .MEM_LAT(1), .MAX_BURST(4)) u_dut (
        .switch_clk(clk), .switch_rst_n(rst_n), .req_re_i(req_re), .req_addr_i(req_addr),
        .req_gnt_o(gnt_a), .rvalid_o(rvalid_a), .rdata_o(rdata_a), .mem_re_o(mre_a),
        .mem_raddr_o(raddr_a), .mem_rdata_i(mem_rdata));

    // Pure round-robin: MAX_BURST=1
    mem_read_arbiter #(.ADDR_W(16), .BLOCK_BYTES(4), .DATA_WIDTH(8), .NUM_PORTS(4),
                       .MEM_LAT(1), .MAX_BURST(1)) u_rr (
        .switch_clk(clk), .switch_rst_n(rst_n), .req_re_i(req_re), .req_addr_i(req_addr),
        .req_gnt_o(gnt_b), .rvalid_o(rvalid_b), .rdata_o(rdata_b), .mem_re_o(mre_b),
        .mem_raddr_o(raddr_b), .mem_rdata_i(mem_rdata));

    // Deep memory: MEM_LAT=3
    mem_read_arbiter #(.ADDR_W(16), .BLOCK_BYTES(4), .DATA_WIDTH(8), .NUM_PORTS(4),
                       .MEM_LAT(3), .MAX_BURST(4)) u_lat3 (
        .switch_clk(clk), .switch_rst_n(rst_n), .req_re_i(req_re), .req_addr_i(req_addr),
        .req_gnt_o(gnt_c), .rvalid_o(rvalid_c), .rdata_o(rdata_c), .mem_re_o(mre_c),
        .mem_raddr_o(raddr_c), .mem_rdata_i(mem_rdata));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n  = 1'b0;
        req_re = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_re    = 4'hF;
        req_addr  = {16'h0333, 16'h0222, 16'h0111, 16'h0055};
        mem_rdata = 32'hDEAD_BEEF;
        #2;
        checks++; if (gnt_a !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt_a); end
        checks++; if (mre_a !== 1'b0) begin errors++; $display("FAIL reset_mem_re: got %b want 0", mre_a); end
        checks++; if (raddr_a !== 16'h0000) begin errors++; $display("FAIL reset_raddr: got %h want 0000", raddr_a); end
        checks++; if (rvalid_a !== 4'b0000) begin errors++; $display("FAIL reset_rvalid: got %b want 0000", rvalid_a); end
        checks++; if (rdata_a[1] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL reset_rdata: got %h want deadbeef", rdata_a[1]); end
        apply_reset();
    endtask

    task automatic test_single_read();
        tick();
        req_re      = 4'b0100;
        req_addr[2] = 16'h0010;
        mem_rdata   = 32'h1111_2222;
        #1;
        checks++; if (gnt_a !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b want 0100", gnt_a); end
        checks++; if (mre_a !== 1'b1) begin errors++; $display("FAIL single_mem_re: got %b want 1", mre_a); end
        checks++; if (raddr_a !== 16'h0010) begin errors++; $display("FAIL single_raddr: got %h want 0010", raddr_a); end
        checks++; if (rvalid_a !== 4'b0000) begin errors++; $display("FAIL single_early_rvalid: got %b want 0000", rvalid_a); end
        tick();
        req_re    = 4'b0000;
        mem_rdata = 32'hA5A5_5A5A;
        #1;
        checks++; if (rvalid_a !== 4'b0100) begin errors++; $display("FAIL single_rvalid: got %b want 0100", rvalid_a); end
        checks++; if (rdata_a[2] !== 32'hA5A5_5A5A) begin errors++; $display("FAIL single_rdata: got %h want a5a55a5a", rdata_a[2]); end
        checks++; if (raddr_a !== 16'h0000) begin errors++; $display("FAIL single_idle_raddr: got %h want 0000", raddr_a); end
        tick();
        #1;
        checks++; if (rvalid_a !== 4'b0000) begin errors++; $display("FAIL single_rvalid_end: got %b want 0000", rvalid_a); end
    endtask

    task automatic test_bursts();
        logic [3:0] exp_a;
        logic [3:0] exp_b;
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            tick();
            req_re = 4'hF;
            #1;
            exp_a = 4'b0001 << ((i < 16) ? (i / 4) : 0);
            exp_b = 4'b0001 << (i % 4);
            checks++; if (gnt_a !== exp_a) begin errors++; $display("FAIL burst4_gnt[%0d]: got %b want %b", i, gnt_a, exp_a); end
            checks++; if (gnt_b !== exp_b) begin errors++; $display("FAIL burst1_gnt[%0d]: got %b want %b", i, gnt_b, exp_b); end
        end
    endtask

    task automatic test_pointer_wrap();
        tick(); req_re = 4'b1000; #1;
        checks++; if (gnt_a !== 4'b1000) begin errors++; $display("FAIL wrap_last3: got %b want 1000", gnt_a); end
        tick(); req_re = 4'b0000; #1;
        checks++; if (gnt_a !== 4'b0000) begin errors++; $display("FAIL wrap_idle: got %b want 0000", gnt_a); end
        tick(); req_re = 4'b0101; #1;
        checks++; if (gnt_a !== 4'b0001) begin errors++; $display("FAIL wrap_first: got %b want 0001", gnt_a); end
        checks++; if (gnt_b !== 4'b0001) begin errors++; $display("FAIL wrap_first_rr: got %b want 0001", gnt_b); end
        tick(); req_re = 4'b0100; #1;
        checks++; if (gnt_a !== 4'b0100) begin errors++; $display("FAIL wrap_second: got %b want 0100", gnt_a); end
    endtask

    task automatic test_burst_cut();
        tick(); req_re = 4'b1000; #1;
        checks++; if (gnt_a !== 4'b1000) begin errors++; $display("FAIL cut_setup: got %b want 1000", gnt_a); end
        for (int i = 0; i < 2; i++) begin
            tick(); req_re = 4'b0011; #1;
            checks++; if (gnt_a !== 4'b0001) begin errors++; $display("FAIL cut_own[%0d]: got %b want 0001", i, gnt_a); end
        end
        for (int i = 0; i < 2; i++) begin
            tick(); req_re = 4'b0010; #1;
            checks++; if (gnt_a !== 4'b0010) begin errors++; $display("FAIL cut_switch[%0d]: got %b want 0010", i, gnt_a); end
        end
    endtask

    task automatic test_stream();
        int         pulses;
        logic [3:0] exp_g;
        logic [3:0] exp_v;
        pulses = 0;
        tick(); req_re = 4'b0000; #1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (k < 10) begin
                req_re      = 4'b1000;
                req_addr[3] = 16'h0300 + 16'(k);
            end else begin
                req_re = 4'b0000;
            end
            #1;
            exp_g = (k < 10) ? 4'b1000 : 4'b0000;
            exp_v = (k >= 1 && k <= 10) ? 4'b1000 : 4'b0000;
            checks++; if (gnt_a !== exp_g) begin errors++; $display("FAIL stream_gnt[%0d]: got %b want %b", k, gnt_a, exp_g); end
            checks++; if (rvalid_a !== exp_v) begin errors++; $display("FAIL stream_rvalid[%0d]: got %b want %b", k, rvalid_a, exp_v); end
            if (k < 10) begin
                checks++; if (raddr_a !== 16'h0300 + 16'(k)) begin errors++; $display("FAIL stream_raddr[%0d]: got %h want %h", k, raddr_a, 16'h0300 + 16'(k)); end
            end
            if (rvalid_a[3] === 1'b1) pulses++;
        end
        checks++; if (pulses != 10) begin errors++; $display("FAIL stream_pulses: got %0d want 10", pulses); end
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            tick(); req_re = 4'b0001; #1;
            checks++; if (gnt_c !== 4'b0001) begin errors++; $display("FAIL mid_gnt[%0d]: got %b want 0001", c, gnt_c); end
            checks++; if (rvalid_c !== 4'b0000) begin errors++; $display("FAIL mid_pre_rvalid[%0d]: got %b want 0000", c, rvalid_c); end
        end
        tick(); rst_n = 1'b0; req_re = 4'b0000; #1;
        checks++; if (rvalid_c !== 4'b0000) begin errors++; $display("FAIL mid_rvalid_c3: got %b want 0000", rvalid_c); end
        checks++; if (gnt_c !== 4'b0000) begin errors++; $display("FAIL mid_gnt_c3: got %b want 0000", gnt_c); end
        tick(); #1;
        checks++; if (rvalid_c !== 4'b0000) begin errors++; $display("FAIL mid_rvalid_c4: got %b want 0000", rvalid_c); end
        tick(); rst_n = 1'b1; req_re = 4'b0011; #1;
        checks++; if (gnt_c !== 4'b0001) begin errors++; $display("FAIL mid_post_gnt: got %b want 0001", gnt_c); end
        checks++; if (rvalid_c !== 4'b0000) begin errors++; $display("FAIL mid_rvalid_c5: got %b want 0000", rvalid_c); end
        for (int c = 6; c < 8; c++) begin
            tick(); req_re = 4'b0000; #1;
            checks++; if (rvalid_c !== 4'b0000) begin errors++; $display("FAIL mid_rvalid_c%0d: got %b want 0000", c, rvalid_c); end
        end
        tick(); #1;
        checks++; if (rvalid_c !== 4'b0001) begin errors++; $display("FAIL mid_new_rvalid: got %b want 0001", rvalid_c); end
        tick(); #1;
        checks++; if (rvalid_c !== 4'b0000) begin errors++; $display("FAIL mid_rvalid_end: got %b want 0000", rvalid_c); end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_re    = 4'b0000;
        req_addr  = '0;
        mem_rdata = '0;
        test_reset();
        test_single_read();
        test_bursts();
        test_pointer_wrap();
        test_burst_cut();
        test_stream();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
